tcm_mem_arb: RTL and testbench

TCM_MEM_ARB -- requirements
Module: tcm_mem_arb

---
 rtl/tcm_mem_arb.sv | 195 +++++++++++++++++++
 tb/tb_tcm_mem_arb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_mem_arb.sv
// tcm_mem_arb: arbitrates one CPU data port and NUM_EXT external requester
// channels onto a single-port 64-bit TCM. One grant per cycle, decided
// combinationally and driven straight onto the memory port. The response
// (ack/error/read data) follows exactly one cycle later.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-low reset
//   cpu_*_i / cpu_accept_o    CPU request (rd, byte strobes, addr, data, tag)
//   cpu_ack_o .. resp_tag_o   CPU response, one cycle after accept
//   ext_*_i / ext_accept_o    per-channel external requests, channel k in slice k
//   ext_ack_o / ext_error_o   per-channel response flags
//   ext_data_rd_o             shared read data for the acked channel
//   mem_*_o / mem_data_i      single-port memory, read data one cycle after en
//
// Address map: [0, ROM) is write-protected, [ROM, ROM+RAM) is writable,
// anything above is out of range (no memory access, error response).
module tcm_mem_arb #(
    parameter int  NUM_EXT      = 2,
    parameter int  TCM_ROM_SIZE = 16384,
    parameter int  TCM_RAM_SIZE = 49152,
    parameter int  STARVE_MAX   = 4,
    parameter int  TAG_W        = 11,
    localparam int MEM_AW       = $clog2((TCM_ROM_SIZE + TCM_RAM_SIZE) / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cpu_rd_i,
    input  logic [3:0]             cpu_wr_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_data_wr_i,
    input  logic [TAG_W-1:0]       cpu_tag_i,
    output logic                   cpu_accept_o,
    output logic                   cpu_ack_o,
    output logic                   cpu_error_o,
    output logic [31:0]            cpu_data_rd_o,
    output logic [TAG_W-1:0]       cpu_resp_tag_o,

    input  logic [NUM_EXT-1:0]     ext_rd_i,
    input  logic [4*NUM_EXT-1:0]   ext_wr_i,
    input  logic [32*NUM_EXT-1:0]  ext_addr_i,
    input  logic [32*NUM_EXT-1:0]  ext_data_wr_i,
    output logic [NUM_EXT-1:0]     ext_accept_o,
    output logic [NUM_EXT-1:0]     ext_ack_o,
    output logic [NUM_EXT-1:0]     ext_error_o,
    output logic [31:0]            ext_data_rd_o,

    output logic                   mem_en_o,
    output logic [7:0]             mem_wr_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic [63:0]            mem_data_o,
    input  logic [63:0]            mem_data_i
);

    localparam int          RR_W     = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int          ST_W     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [ST_W-1:0] ST_MAX_V = ST_W'(STARVE_MAX);
    localparam logic [31:0] ROM_END  = 32'(TCM_ROM_SIZE);
    localparam logic [31:0] TCM_END  = 32'(TCM_ROM_SIZE + TCM_RAM_SIZE);

    logic [RR_W-1:0]    rr_q;
    logic [ST_W-1:0]    starve_q;

    logic               cpu_req;
    logic [NUM_EXT-1:0] ext_req;
    logic               ext_any;
    logic [RR_W-1:0]    ext_win;
    logic [RR_W-1:0]    cand;
    logic               ext_hit;
    logic               force_ext;
    logic               grant_cpu;
    logic               grant_ext;
    logic               grant;

    logic [3:0]         sel_wr;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_data;
    logic               in_range;
    logic               rom_wr;

    logic               rsp_cpu_q;
    logic [NUM_EXT-1:0] rsp_ext_q;
    logic               rsp_err_q;
    logic               rsp_hi_q;
    logic               rsp_oob_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [31:0]        rd_word;

    // ---------------------------------------------------------------
    // Request detection and round-robin scan starting at rr_q
    // ---------------------------------------------------------------
    assign cpu_req = cpu_rd_i | (|cpu_wr_i);

    always_comb begin
        ext_req = '0;
        for (int k = 0; k < NUM_EXT; k++)
            ext_req[k] = ext_rd_i[k] | (|ext_wr_i[4*k +: 4]);
    end

    assign ext_any = |ext_req;

    always_comb begin
        ext_win = '0;
        ext_hit = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            cand = RR_W'((int'(rr_q) + i) % NUM_EXT);
            if (!ext_hit && ext_req[cand]) begin
                ext_win = cand;
                ext_hit = 1'b1;
            end
        end
    end

    // A waiting channel that has watched the CPU win STARVE_MAX cycles in a
    // row takes the port this cycle regardless of the CPU.
    assign force_ext = (STARVE_MAX != 0) && (starve_q == ST_MAX_V) && ext_any;
    assign grant_cpu = cpu_req && !force_ext;
    assign grant_ext = ext_any && !grant_cpu;
    assign grant     = grant_cpu | grant_ext;

    assign cpu_accept_o = grant_cpu;
    assign ext_accept_o = grant_ext ? (NUM_EXT'(1) << ext_win) : '0;

    // ---------------------------------------------------------------
    // Winner's fields onto the memory port
    // ---------------------------------------------------------------
    always_comb begin
        sel_wr   = cpu_wr_i;
        sel_addr = cpu_addr_i;
        sel_data = cpu_data_wr_i;
        if (!grant_cpu) begin
            sel_wr   = ext_wr_i[4*ext_win +: 4];
            sel_addr = ext_addr_i[32*ext_win +: 32];
            sel_data = ext_data_wr_i[32*ext_win +: 32];
        end
    end

    assign in_range = sel_addr < TCM_END;
    assign rom_wr   = (|sel_wr) && (sel_addr < ROM_END);

    // ROM writes still enable the memory (a harmless read) but never write.
    assign mem_en_o   = grant && in_range;
    assign mem_wr_o   = (mem_en_o && !rom_wr) ?
                        (sel_addr[2] ? {sel_wr, 4'b0000} : {4'b0000, sel_wr}) : 8'h00;
    assign mem_addr_o = mem_en_o ? sel_addr[MEM_AW+2:3] : '0;
    assign mem_data_o = {sel_data, sel_data};

    // ---------------------------------------------------------------
    // State: round-robin pointer, starvation counter, response stage
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q      <= '0;
            starve_q  <= '0;
            rsp_cpu_q <= 1'b0;
            rsp_ext_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_hi_q  <= 1'b0;
            rsp_oob_q <= 1'b0;
            rsp_tag_q <= '0;
        end else begin
            rsp_cpu_q <= grant_cpu;
            rsp_ext_q <= ext_accept_o;
            rsp_err_q <= grant && (!in_range || rom_wr);
            rsp_hi_q  <= sel_addr[2];
            rsp_oob_q <= !in_range;
            if (grant_cpu)
                rsp_tag_q <= cpu_tag_i;

            if (grant_ext)
                rr_q <= RR_W'((int'(ext_win) + 1) % NUM_EXT);

            if (grant_ext || !ext_any)
                starve_q <= '0;
            else if (grant_cpu && starve_q != ST_MAX_V)
                starve_q <= starve_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Response outputs; out-of-range accesses return zero data
    // ---------------------------------------------------------------
    assign rd_word = rsp_hi_q ? mem_data_i[63:32] : mem_data_i[31:0];

    assign cpu_ack_o      = rsp_cpu_q;
    assign cpu_error_o    = rsp_cpu_q & rsp_err_q;
    assign cpu_data_rd_o  = (rsp_cpu_q && !rsp_oob_q) ? rd_word : 32'h0;
    assign cpu_resp_tag_o = rsp_tag_q;

    assign ext_ack_o      = rsp_ext_q;
    assign ext_error_o    = rsp_ext_q & {NUM_EXT{rsp_err_q}};
    assign ext_data_rd_o  = ((|rsp_ext_q) && !rsp_oob_q) ? rd_word : 32'h0;

endmodule

// File: tb/tb_tcm_mem_arb.sv
// Bench for tcm_mem_arb: queue-fed requesters, a behavioural memory, and a
// byte-addressed reference model checked every cycle, plus literal checks
// on logged accept/ack sequences for the directed scenarios.
module tb_tcm_mem_arb;
    localparam int NUM_EXT = 2;
    localparam int ROM     = 16384;
    localparam int RAM     = 49152;
    localparam int SMAX    = 4;
    localparam int TAG_W   = 11;
    localparam int MEM_AW  = 13;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic               cpu_rd_i;
    logic [3:0]         cpu_wr_i;
    logic [31:0]        cpu_addr_i, cpu_data_wr_i;
    logic [TAG_W-1:0]   cpu_tag_i;
    logic               cpu_accept_o, cpu_ack_o, cpu_error_o;
    logic [31:0]        cpu_data_rd_o;
    logic [TAG_W-1:0]   cpu_resp_tag_o;
    logic [NUM_EXT-1:0] ext_rd_i;
    logic [4*NUM_EXT-1:0]  ext_wr_i;
    logic [32*NUM_EXT-1:0] ext_addr_i, ext_data_wr_i;
    logic [NUM_EXT-1:0] ext_accept_o, ext_ack_o, ext_error_o;
    logic [31:0]        ext_data_rd_o;
    logic               mem_en_o;
    logic [7:0]         mem_wr_o;
    logic [MEM_AW-1:0]  mem_addr_o;
    logic [63:0]        mem_data_o, mem_data_i;

    tcm_mem_arb #(.NUM_EXT(NUM_EXT), .TCM_ROM_SIZE(ROM), .TCM_RAM_SIZE(RAM),
                  .STARVE_MAX(SMAX), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_wr_i(cpu_data_wr_i), .cpu_tag_i(cpu_tag_i),
        .cpu_accept_o(cpu_accept_o), .cpu_ack_o(cpu_ack_o), .cpu_error_o(cpu_error_o),
        .cpu_data_rd_o(cpu_data_rd_o), .cpu_resp_tag_o(cpu_resp_tag_o),
        .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
        .ext_data_wr_i(ext_data_wr_i), .ext_accept_o(ext_accept_o),
        .ext_ack_o(ext_ack_o), .ext_error_o(ext_error_o), .ext_data_rd_o(ext_data_rd_o),
        .mem_en_o(mem_en_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        return {32'hC0DE0000 | 32'(2*i + 1), 32'hC0DE0000 | 32'(2*i)};
    endfunction

    // Memory behind the port (written only by the DUT) and reference bytes
    logic [63:0] env_mem [0:8191];
    logic [7:0]  bmem    [0:65535];
    logic [63:0] mem_rd_q;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            env_mem[i] = init_word(i);
            for (int b = 0; b < 8; b++) bmem[8*i + b] = env_mem[i][8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_en_o) begin
            mem_rd_q <= env_mem[mem_addr_o];
            for (int b = 0; b < 8; b++)
                if (mem_wr_o[b]) env_mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
        end
    end
    assign mem_data_i = mem_rd_q;

    // ---------------------------------------------------------------
    // Requesters: each holds its current entry until accepted; an entry
    // with no rd and no strobes is a one-cycle idle gap.
    // ---------------------------------------------------------------
    typedef struct {
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [10:0] tag;
    } req_t;

    function automatic req_t mk(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [10:0] tg);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.data = d; r.tag = tg;
        return r;
    endfunction

    req_t cpu_q[$];
    req_t e0_q[$];
    req_t e1_q[$];
    req_t cur_c;
    req_t cur_e[2];
    bit   cv;
    bit   ev[2];
    bit   took_c;
    bit   took_e[2];

    always @(negedge clk) begin
        took_c    = cpu_accept_o;
        took_e[0] = ext_accept_o[0];
        took_e[1] = ext_accept_o[1];
    end

    always begin
        @(posedge clk);
        #1;
        if (!rst_i) begin
            cv = 0; ev[0] = 0; ev[1] = 0;
        end else begin
            if (cv && (took_c || !(cur_c.rd || (|cur_c.wr)))) cv = 0;
            if (!cv && cpu_q.size() > 0) begin cur_c = cpu_q.pop_front(); cv = 1; end
            for (int k = 0; k < 2; k++) begin
                if (ev[k] && (took_e[k] || !(cur_e[k].rd || (|cur_e[k].wr)))) ev[k] = 0;
                if (!ev[k]) begin
                    if (k == 0 && e0_q.size() > 0) begin cur_e[k] = e0_q.pop_front(); ev[k] = 1; end
                    if (k == 1 && e1_q.size() > 0) begin cur_e[k] = e1_q.pop_front(); ev[k] = 1; end
                end
            end
        end
        cpu_rd_i      = cv & cur_c.rd;
        cpu_wr_i      = cv ? cur_c.wr   : 4'h0;
        cpu_addr_i    = cv ? cur_c.addr : 32'h0;
        cpu_data_wr_i = cv ? cur_c.data : 32'h0;
        cpu_tag_i     = cv ? cur_c.tag  : 11'h0;
        for (int k = 0; k < 2; k++) begin
            ext_rd_i[k]              = ev[k] & cur_e[k].rd;
            ext_wr_i[4*k +: 4]       = ev[k] ? cur_e[k].wr   : 4'h0;
            ext_addr_i[32*k +: 32]   = ev[k] ? cur_e[k].addr : 32'h0;
            ext_data_wr_i[32*k +: 32] = ev[k] ? cur_e[k].data : 32'h0;
        end
    end

    // ---------------------------------------------------------------
    // Reference model and per-cycle compare
    // ---------------------------------------------------------------
    typedef struct { int cyc; int who; logic en; logic [7:0] wr; } acc_t;
    typedef struct { int cyc; int who; logic err; logic [31:0] data; } ack_t;
    acc_t acc_log[$];
    ack_t ack_log[$];

    int          m_rr, m_starve;
    bit          p_v;
    int          p_who;
    logic        p_err, p_chk;
    logic [31:0] p_data;
    logic [10:0] p_tag;

    bit          cr, eany, gv, inr, romw;
    bit          er[2];
    int          w, who, ai;
    logic [31:0] a, d;
    logic [3:0]  wr;
    logic [10:0] tg;
    logic [7:0]  ewr;

    always @(negedge clk) begin
        cyc++;
        if (!rst_i) begin
            chk("rst_cpu_ack",  cpu_ack_o, 0);
            chk("rst_cpu_err",  cpu_error_o, 0);
            chk("rst_cpu_data", cpu_data_rd_o, 0);
            chk("rst_cpu_tag",  cpu_resp_tag_o, 0);
            chk("rst_ext_ack",  ext_ack_o, 0);
            chk("rst_ext_err",  ext_error_o, 0);
            chk("rst_ext_data", ext_data_rd_o, 0);
            m_rr = 0; m_starve = 0; p_v = 0;
        end else begin
            // response for last cycle's grant
            chk("cpu_ack", cpu_ack_o, p_v && p_who < 0);
            chk("ext_ack", ext_ack_o, (p_v && p_who >= 0) ? (2'b01 << p_who) : 2'b00);
            if (p_v && p_who < 0) begin
                chk("cpu_err", cpu_error_o, p_err);
                chk("cpu_tag", cpu_resp_tag_o, p_tag);
                if (p_chk) chk("cpu_data", cpu_data_rd_o, p_data);
            end
            if (p_v && p_who >= 0) begin
                chk("ext_err", ext_error_o, p_err ? (2'b01 << p_who) : 2'b00);
                if (p_chk) chk("ext_data", ext_data_rd_o, p_data);
            end
            if (cpu_ack_o) ack_log.push_back('{cyc, -1, cpu_error_o, cpu_data_rd_o});
            for (int k = 0; k < 2; k++)
                if (ext_ack_o[k]) ack_log.push_back('{cyc, k, ext_error_o[k], ext_data_rd_o});

            // who should win this cycle
            cr    = cpu_rd_i || (cpu_wr_i != 0);
            er[0] = ext_rd_i[0] || (ext_wr_i[3:0] != 0);
            er[1] = ext_rd_i[1] || (ext_wr_i[7:4] != 0);
            eany  = er[0] || er[1];
            w = -1;
            for (int i = 0; i < 2; i++)
                if (w < 0 && er[(m_rr + i) % 2]) w = (m_rr + i) % 2;
            gv  = 1;
            who = -1;
            if (cr && !(m_starve == SMAX && eany)) who = -1;
            else if (eany) who = w;
            else gv = 0;

            chk("cpu_accept", cpu_accept_o, gv && who < 0);
            chk("ext_accept", ext_accept_o, (gv && who >= 0) ? (2'b01 << who) : 2'b00);

            if (who < 0) begin a = cpu_addr_i; d = cpu_data_wr_i; wr = cpu_wr_i; tg = cpu_tag_i; end
            else begin
                a = ext_addr_i[32*who +: 32]; d = ext_data_wr_i[32*who +: 32];
                wr = ext_wr_i[4*who +: 4]; tg = 11'h0;
            end
            inr  = a < ROM + RAM;
            romw = (wr != 0) && (a < ROM);
            ewr  = 8'h00;
            if (gv && inr && !romw) ewr = a[2] ? {wr, 4'h0} : {4'h0, wr};
            chk("mem_en", mem_en_o, gv && inr);
            chk("mem_wr", mem_wr_o, ewr);
            if (gv && inr) chk("mem_addr", mem_addr_o, a >> 3);
            if (ewr != 0)  chk("mem_data", mem_data_o, {d, d});

            // record response due next cycle, then apply the access
            p_v = gv; p_who = who; p_tag = tg;
            p_err = !inr || romw;
            p_chk = (wr == 0) || !inr;
            ai = int'(a[15:2]) * 4;
            p_data = inr ? {bmem[ai+3], bmem[ai+2], bmem[ai+1], bmem[ai]} : 32'h0;
            if (gv && inr && !romw)
                for (int b = 0; b < 4; b++) if (wr[b]) bmem[ai + b] = d[8*b +: 8];

            if (gv && who >= 0) m_rr = (who + 1) % 2;
            if ((gv && who >= 0) || !eany) m_starve = 0;
            else if (gv && m_starve < SMAX) m_starve++;

            if (cpu_accept_o) acc_log.push_back('{cyc, -1, mem_en_o, mem_wr_o});
            for (int k = 0; k < 2; k++)
                if (ext_accept_o[k]) acc_log.push_back('{cyc, k, mem_en_o, mem_wr_o});
        end
    end

    // ---------------------------------------------------------------
    // Helpers for the directed scenarios
    // ---------------------------------------------------------------
    task automatic run_until_idle(input string nm);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cpu_q.size() == 0 && e0_q.size() == 0 && e1_q.size() == 0 &&
                !cv && !ev[0] && !ev[1]) break;
        end
        if (n >= 200) chk({nm, "_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clr_logs();
        acc_log.delete();
        ack_log.delete();
    endtask

    task automatic chk_acc(input string nm, input int i, input int who_e, input int dcyc);
        if (acc_log.size() <= i) chk({nm, "_count"}, acc_log.size(), i + 1);
        else begin
            chk({nm, "_who"}, acc_log[i].who, who_e);
            chk({nm, "_cyc"}, acc_log[i].cyc - acc_log[0].cyc, dcyc);
        end
    endtask

    task automatic chk_ack(input string nm, input int i, input int who_e,
                           input logic err, input logic [31:0] data, input bit use_data);
        if (ack_log.size() <= i) chk({nm, "_count"}, ack_log.size(), i + 1);
        else begin
            chk({nm, "_who"}, ack_log[i].who, who_e);
            chk({nm, "_err"}, ack_log[i].err, err);
            if (use_data) chk({nm, "_data"}, ack_log[i].data, data);
        end
    endtask

    // ---------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------
    initial begin
        int n;
        rst_i = 1'b0;
        cpu_rd_i = 0; cpu_wr_i = 0; cpu_addr_i = 0; cpu_data_wr_i = 0; cpu_tag_i = 0;
        ext_rd_i = 0; ext_wr_i = 0; ext_addr_i = 0; ext_data_wr_i = 0;
        repeat (3) @(negedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);

        // two channels, CPU idle: strict alternation starting at channel 0
        clr_logs();
        for (int i = 0; i < 4; i++) begin
            e0_q.push_back(mk(1, 4'h0, 32'h4000 + 8*i, 0, 0));
            e1_q.push_back(mk(1, 4'h0, 32'h5000 + 8*i, 0, 0));
        end
        run_until_idle("rr");
        for (int i = 0; i < 8; i++) chk_acc("rr_alt", i, i % 2, i);

        // CPU beats ext0 in the same cycle; ext0 goes next
        clr_logs();
        cpu_q.push_back(mk(1, 4'h0, 32'h4004, 0, 11'h123));
        e0_q.push_back(mk(1, 4'h0, 32'h4000, 0, 0));
        run_until_idle("prio");
        chk_acc("prio_a0", 0, -1, 0);
        chk_acc("prio_a1", 1, 0, 1);
        chk_ack("prio_k0", 0, -1, 0, 32'hC0DE1001, 1);
        chk_ack("prio_k1", 1, 0, 0, 32'hC0DE1000, 1);
        if (ack_log.size() >= 2) chk("prio_ack_cyc", ack_log[1].cyc - ack_log[0].cyc, 1);

        // CPU streaming, ext1 waiting: forced through on the 5th cycle
        clr_logs();
        for (int i = 0; i < 8; i++) cpu_q.push_back(mk(1, 4'h0, 32'h8000 + 8*i, 0, 11'(i)));
        e1_q.push_back(mk(1, 4'h0, 32'h9000, 0, 0));
        run_until_idle("starve");
        for (int i = 0; i < 9; i++) chk_acc("starve", i, (i == 4) ? 1 : -1, i);

        // ROM write rejected, ROM contents unchanged
        clr_logs();
        cpu_q.push_back(mk(0, 4'hF, 32'h0010, 32'hDEADBEEF, 11'h7));
        cpu_q.push_back(mk(1, 4'h0, 32'h0010, 0, 11'h8));
        run_until_idle("rom");
        if (acc_log.size() > 0) begin
            chk("rom_wr_en", acc_log[0].en, 1);
            chk("rom_wr_strb", acc_log[0].wr, 8'h00);
        end
        chk_ack("rom_k0", 0, -1, 1, 0, 0);
        chk_ack("rom_k1", 1, -1, 0, 32'hC0DE0004, 1);

        // RAM partial writes into both halves, read back
        clr_logs();
        cpu_q.push_back(mk(0, 4'b0101, 32'h4008, 32'h11223344, 11'h1));
        cpu_q.push_back(mk(0, 4'b1100, 32'h400C, 32'hAABBCCDD, 11'h2));
        cpu_q.push_back(mk(1, 4'h0, 32'h4008, 0, 11'h3));
        cpu_q.push_back(mk(1, 4'h0, 32'h400C, 0, 11'h4));
        run_until_idle("ram");
        if (acc_log.size() > 1) begin
            chk("ram_strb_lo", acc_log[0].wr, 8'h05);
            chk("ram_strb_hi", acc_log[1].wr, 8'hC0);
        end
        chk_ack("ram_k2", 2, -1, 0, 32'hC0221044, 1);
        chk_ack("ram_k3", 3, -1, 0, 32'hAABB1003, 1);

        // external write path, then read back on the other channel
        clr_logs();
        e1_q.push_back(mk(0, 4'b0011, 32'h6000, 32'h0000BEEF, 0));
        run_until_idle("extw");
        e0_q.push_back(mk(1, 4'h0, 32'h6000, 0, 0));
        run_until_idle("extr");
        chk_ack("ext_rb", 1, 0, 0, 32'hC0DEBEEF, 1);

        // range boundaries
        clr_logs();
        cpu_q.push_back(mk(1, 4'h0, 32'h0001_0000, 0, 11'h10));
        cpu_q.push_back(mk(1, 4'h0, 32'h3FFC, 0, 11'h11));
        cpu_q.push_back(mk(0, 4'h1, 32'h3FFC, 32'h55, 11'h12));
        cpu_q.push_back(mk(0, 4'h1, 32'h4000, 32'h77, 11'h13));
        run_until_idle("bnd");
        if (acc_log.size() > 0) chk("oob_en", acc_log[0].en, 0);
        chk_ack("oob_k0", 0, -1, 1, 32'h0, 1);
        chk_ack("bnd_k1", 1, -1, 0, 32'hC0DE0FFF, 1);
        chk_ack("bnd_k2", 2, -1, 1, 0, 0);
        chk_ack("bnd_k3", 3, -1, 0, 0, 0);
        clr_logs();
        e1_q.push_back(mk(1, 4'h0, 32'hFFFC, 0, 0));
        e0_q.push_back(mk(0, 4'hF, 32'hFFFF_FFF0, 32'h1, 0));
        run_until_idle("bnd_ext");
        chk("bnd_ext_n", ack_log.size(), 2);

        // reset right after an accept: response dropped, pointer cleared
        e0_q.push_back(mk(1, 4'h0, 32'h4010, 0, 0));
        run_until_idle("pre_rst");
        cpu_q.push_back(mk(1, 4'h0, 32'h4000, 0, 11'h5));
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cpu_accept_o) break;
        end
        if (n >= 20) chk("mid_rst_accept_timeout", 1, 0);
        @(posedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_ack", cpu_ack_o, 0);
        @(negedge clk);
        #1 rst_i = 1'b1;
        clr_logs();
        e0_q.push_back(mk(1, 4'h0, 32'h4000, 0, 0));
        e1_q.push_back(mk(1, 4'h0, 32'h4008, 0, 0));
        run_until_idle("post_rst");
        chk_acc("post_rst_a0", 0, 0, 0);
        chk_acc("post_rst_a1", 1, 1, 1);
        chk("post_rst_acks", ack_log.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want done");
        $fatal(1);
    end

endmodule
